instr_ctrl_fsm: RTL and testbench

Instruction register, decoder and control state machine that sits directly upstream of the datapath. It latches a 16-bit instruction and sequences multi-cycle execution. It drives every datapath control strobe (`readnum`, `writenum`, `vsel`, `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads`, `write`, `shift`, `ALUop`) plus the sign-extended immediates. It reports idle via `w`.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/instr_dec.sv | 41 ++++
 rtl/instr_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_instr_ctrl_fsm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the instruction register / control FSM slice.
// Opcode, op and vsel encodings match the datapath's instruction set.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // MOV sub-ops share the op field with the ALU ops
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_C     = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_PC    = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational field extraction and immediate sign extension from the
// latched instruction register.
module instr_dec #(
    parameter int IW = 16,
    parameter int RW = 3
) (
    input  logic [IW-1:0] ir,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [RW-1:0] rn,
    output logic [RW-1:0] rd,
    output logic [1:0]    sh,
    output logic [RW-1:0] rm,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[8 +: RW];
    assign rd     = ir[5 +: RW];
    assign sh     = ir[4:3];
    assign rm     = ir[0 +: RW];

    genvar gi;
    generate
        for (gi = 0; gi < IW; gi++) begin : g_sx
            if (gi < 8) begin : g_imm8_lo
                assign sximm8[gi] = ir[gi];
            end else begin : g_imm8_hi
                assign sximm8[gi] = ir[7];
            end
            if (gi < 5) begin : g_imm5_lo
                assign sximm5[gi] = ir[gi];
            end else begin : g_imm5_hi
                assign sximm5[gi] = ir[4];
            end
        end
    endgenerate

endmodule

// File: rtl/instr_ctrl_fsm.sv
// Instruction register plus multi-cycle control sequencer for the datapath.
// Strobes are registered: each is set on the edge that enters the state owning it.
module instr_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int IW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] in,
    input  logic          load,
    input  logic          s,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic [1:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic          loadc,
    output logic          loads,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5
);

    state_t        state_reg;
    logic [IW-1:0] ir_reg;
    logic          w_reg;
    logic [RW-1:0] readnum_reg;
    logic [RW-1:0] writenum_reg;
    logic          write_reg;
    logic [1:0]    vsel_reg;
    logic          loada_reg;
    logic          loadb_reg;
    logic          asel_reg;
    logic          bsel_reg;
    logic          loadc_reg;
    logic          loads_reg;

    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [RW-1:0] rm;
    logic [1:0]    sh;

    instr_dec #(.IW(IW), .RW(RW)) u_dec (
        .ir     (ir_reg),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_WAIT;
            ir_reg       <= '0;
            w_reg        <= 1'b1;
            readnum_reg  <= '0;
            writenum_reg <= '0;
            write_reg    <= 1'b0;
            vsel_reg     <= VSEL_MDATA;
            loada_reg    <= 1'b0;
            loadb_reg    <= 1'b0;
            asel_reg     <= 1'b0;
            bsel_reg     <= 1'b0;
            loadc_reg    <= 1'b0;
            loads_reg    <= 1'b0;
        end else begin
            readnum_reg  <= '0;
            writenum_reg <= '0;
            write_reg    <= 1'b0;
            vsel_reg     <= VSEL_MDATA;
            loada_reg    <= 1'b0;
            loadb_reg    <= 1'b0;
            asel_reg     <= 1'b0;
            bsel_reg     <= 1'b0;
            loadc_reg    <= 1'b0;
            loads_reg    <= 1'b0;
            case (state_reg)
                S_WAIT: begin
                    if (load) ir_reg <= in;
                    if (s) begin
                        state_reg <= S_DECODE;
                        w_reg     <= 1'b0;
                    end
                end
                // IR is frozen from here on, so the entering-state strobes may use its fields
                S_DECODE: begin
                    if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
                        state_reg    <= S_WRITE_IMM;
                        writenum_reg <= rn;
                        vsel_reg     <= VSEL_IMM8;
                        write_reg    <= 1'b1;
                    end else if (opcode == OPC_MOV && op == OP_MOV_REG) begin
                        state_reg   <= S_GET_B;
                        readnum_reg <= rm;
                        loadb_reg   <= 1'b1;
                    end else if (opcode == OPC_ALU) begin
                        state_reg   <= S_GET_A;
                        readnum_reg <= rn;
                        loada_reg   <= 1'b1;
                    end else begin
                        state_reg <= S_WAIT;
                        w_reg     <= 1'b1;
                    end
                end
                S_GET_A: begin
                    state_reg   <= S_GET_B;
                    readnum_reg <= rm;
                    loadb_reg   <= 1'b1;
                end
                S_GET_B: begin
                    state_reg <= S_ALU;
                    loadc_reg <= 1'b1;
                    if (opcode == OPC_MOV) asel_reg  <= 1'b1;
                    else                   loads_reg <= 1'b1;
                end
                S_ALU: begin
                    if (opcode == OPC_ALU && op == OP_CMP) begin
                        state_reg <= S_WAIT;
                        w_reg     <= 1'b1;
                    end else begin
                        state_reg    <= S_WRITE_REG;
                        writenum_reg <= rd;
                        vsel_reg     <= VSEL_C;
                        write_reg    <= 1'b1;
                    end
                end
                S_WRITE_IMM, S_WRITE_REG: begin
                    state_reg <= S_WAIT;
                    w_reg     <= 1'b1;
                end
                default: begin
                    state_reg <= S_WAIT;
                    w_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign w        = w_reg;
    assign readnum  = readnum_reg;
    assign writenum = writenum_reg;
    assign write    = write_reg;
    assign vsel     = vsel_reg;
    assign loada    = loada_reg;
    assign loadb    = loadb_reg;
    assign asel     = asel_reg;
    assign bsel     = bsel_reg;
    assign loadc    = loadc_reg;
    assign loads    = loads_reg;
    assign shift    = sh;
    assign ALUop    = op;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Bench for instr_ctrl_fsm: directed scenarios then random traffic, checked
// cycle by cycle against a per-instruction micro-step plan model.
module tb_instr_ctrl_fsm;

    localparam int IW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset, load, s;
    logic [IW-1:0] in;
    logic          w, write, loada, loadb, asel, bsel, loadc, loads;
    logic [RW-1:0] readnum, writenum;
    logic [1:0]    vsel, shift, ALUop;
    logic [IW-1:0] sximm8, sximm5;

    instr_ctrl_fsm #(.IW(IW), .RW(RW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .loadc    (loadc),
        .loads    (loads),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [15:0] m_ir  = '0;
    logic [15:0] plan[$];

    // Idle: only w set; every strobe at its default
    localparam logic [15:0] IDLE = 16'h8000;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads}
    function automatic logic [15:0] rec(input logic [2:0] rdn, input logic [2:0] wrn,
                                        input logic wr, input logic [1:0] vs,
                                        input logic la, input logic lb, input logic as,
                                        input logic lc, input logic ls);
        return {1'b0, rdn, wrn, wr, vs, la, lb, as, 1'b0, lc, ls};
    endfunction

    // Expected output of every busy cycle for one instruction, in order
    function automatic void build_plan(input logic [15:0] ir);
        logic [2:0] opc = ir[15:13];
        logic [1:0] op  = ir[12:11];
        logic [2:0] rn  = ir[10:8];
        logic [2:0] rd  = ir[7:5];
        logic [2:0] rm  = ir[2:0];
        plan.push_back(rec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        if (opc == 3'b110 && op == 2'b10) begin
            plan.push_back(rec(0, rn, 1, 2'b10, 0, 0, 0, 0, 0));
        end else if (opc == 3'b110 && op == 2'b00) begin
            plan.push_back(rec(rm, 0, 0, 2'b00, 0, 1, 0, 0, 0));
            plan.push_back(rec(0, 0, 0, 2'b00, 0, 0, 1, 1, 0));
            plan.push_back(rec(0, rd, 1, 2'b01, 0, 0, 0, 0, 0));
        end else if (opc == 3'b101) begin
            plan.push_back(rec(rn, 0, 0, 2'b00, 1, 0, 0, 0, 0));
            plan.push_back(rec(rm, 0, 0, 2'b00, 0, 1, 0, 0, 0));
            plan.push_back(rec(0, 0, 0, 2'b00, 0, 0, 0, 1, 1));
            if (op != 2'b01) plan.push_back(rec(0, rd, 1, 2'b01, 0, 0, 0, 0, 0));
        end
    endfunction

    task automatic step(input logic ld, input logic st, input logic rs, input logic [15:0] word);
        logic [15:0]        e;
        logic signed [15:0] x8;
        logic signed [15:0] x5;
        load  = ld;
        s     = st;
        reset = rs;
        in    = word;
        @(posedge clk);
        cyc++;
        if (rs) begin
            plan.delete();
            m_ir = '0;
        end else if (plan.size() == 0) begin
            if (ld) m_ir = word;
            if (st) begin
                build_plan(m_ir);
                $display("cycle %0d: start instr %h (%0d busy cycles)", cyc, m_ir, plan.size());
            end
        end else begin
            void'(plan.pop_front());
        end
        #1;
        e  = (plan.size() != 0) ? plan[0] : IDLE;
        x8 = $signed(m_ir[7:0]);
        x5 = $signed(m_ir[4:0]);
        check_val("ctrl", {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads}, e);
        check_val("imm", {shift, ALUop, sximm8, sximm5}, {m_ir[4:3], m_ir[12:11], x8, x5});
    endtask

    initial begin
        logic [15:0] word;
        reset = 1'b1; load = 1'b0; s = 1'b0; in = '0;

        step(1, 0, 1, 16'hFFFF);
        step(0, 0, 1, 16'h0000);

        // MOV R0,#7 with load and s together
        step(1, 1, 0, 16'hD007);
        repeat (3) step(0, 0, 0, 16'h0000);

        // ADD R2,R1,R0 LSL#1; loads while busy must be ignored
        step(1, 0, 0, 16'hA148);
        step(0, 1, 0, 16'h0000);
        repeat (5) step(1, 0, 0, 16'hD007);
        check_val("ir_held", sximm8, 16'h0048);
        step(0, 0, 0, 16'h0000);

        // CMP R3,R4
        step(1, 1, 0, 16'hAB04);
        repeat (5) step(0, 0, 0, 16'h0000);

        // MOV R5,#-3
        step(1, 1, 0, 16'hD5FD);
        check_val("sximm8_neg", sximm8, 16'hFFFD);
        check_val("sximm5_neg", sximm5, 16'hFFFD);
        repeat (3) step(0, 0, 0, 16'h0000);

        // Undefined encoding is dropped
        step(1, 1, 0, 16'h0000);
        repeat (2) step(0, 0, 0, 16'h0000);

        // Reset during GET_B of ADD
        step(1, 1, 0, 16'hA148);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0000);
        check_val("rst_w", w, 1'b1);
        check_val("rst_ir", sximm8, 16'h0000);
        step(0, 0, 0, 16'h0000);

        // Random traffic, including s held high and sporadic resets
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       word = {3'b110, 2'b10, 11'($urandom)};
                1:       word = {3'b110, 2'b00, 11'($urandom)};
                2, 3:    word = {3'b101, 13'($urandom)};
                default: word = 16'($urandom);
            endcase
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) == 0), word);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
